// File: rtl/merger_pkg.sv
// merger_pkg: shared constants for the merger coord/fetch interface.
package merger_pkg;
  localparam int COORD_BITS_DEFAULT = 32;
  localparam int FIFO_DEPTH_DEFAULT = 4;
  localparam logic [COORD_BITS_DEFAULT-1:0] COORD_SENTINEL = '1;
  function automatic int ptr_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction
  localparam int PTR_BITS_DEFAULT = ptr_bits(FIFO_DEPTH_DEFAULT);
endpackage

// File: rtl/merger_coord_feeder_if.sv
// merger_coord_feeder_if: push side, merger coord/fetch side and status of the feeder.
interface merger_coord_feeder_if #(parameter int W = 32, parameter int R = 2);
  logic [R*W-1:0] in_coord;
  logic [R-1:0] in_valid;
  logic [R-1:0] in_last;
  logic [R-1:0] in_ready;
  logic [R*W-1:0] coord_out;
  logic [R-1:0] lane_valid;
  logic [R-1:0] fetch_next;
  logic done;
  logic underflow;
  modport master(output in_coord, in_valid, in_last, fetch_next,
                 input in_ready, coord_out, lane_valid, done, underflow);
  modport slave(input in_coord, in_valid, in_last, fetch_next,
                output in_ready, coord_out, lane_valid, done, underflow);
endinterface

// File: rtl/coord_fifo_lane.sv
// coord_fifo_lane: one coordinate FIFO plus its end-of-fiber flag.
module coord_fifo_lane
  import merger_pkg::*;
#(
  parameter int W = COORD_BITS_DEFAULT,
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic push,
  input  logic [W-1:0] data,
  input  logic last,
  input  logic pop,
  input  logic clr_last,
  output logic ready,
  output logic [W-1:0] head,
  output logic valid,
  output logic drained,
  output logic pop_empty
);
  localparam int P = ptr_bits(DEPTH);
  logic [P-1:0] wr_ptr, rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic last_seen, empty, full, wr_en, rd_en;
  // extra top pointer bit distinguishes full from empty when low bits match
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[P-2:0] == rd_ptr[P-2:0]) && (wr_ptr[P-1] != rd_ptr[P-1]);
  assign ready = reset_n & !full & !last_seen;
  assign wr_en = push & ready;
  assign rd_en = pop & !empty;
  assign pop_empty = pop & empty;
  assign valid = reset_n & !empty;
  assign head = valid ? mem[rd_ptr[P-2:0]] : {W{1'b1}};
  assign drained = last_seen & empty;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_seen <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (clr_last) last_seen <= 1'b0;
      else if (wr_en & last) last_seen <= 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr[P-2:0]] <= data;
  end
endmodule

// File: rtl/merger_coord_feeder.sv
// merger_coord_feeder: buffers R coordinate fibers and presents lane heads to the merger.
module merger_coord_feeder
  import merger_pkg::*;
#(
  parameter int MERGER_COORD_BITS = COORD_BITS_DEFAULT,
  parameter int MERGER_RADIX = 2,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input logic clock,
  input logic reset_n,
  merger_coord_feeder_if.slave bus
);
  localparam int W = MERGER_COORD_BITS;
  logic [MERGER_RADIX-1:0] drained, pop_empty;
  logic done_next, done_q, underflow_q;
  assign done_next = &drained;
  for (genvar i = 0; i < MERGER_RADIX; i++) begin : g_lane
    coord_fifo_lane #(.W(W), .DEPTH(FIFO_DEPTH)) lane (
      .clock(clock),
      .reset_n(reset_n),
      .push(bus.in_valid[i]),
      .data(bus.in_coord[i*W +: W]),
      .last(bus.in_last[i]),
      .pop(bus.fetch_next[i]),
      .clr_last(done_next),
      .ready(bus.in_ready[i]),
      .head(bus.coord_out[i*W +: W]),
      .valid(bus.lane_valid[i]),
      .drained(drained[i]),
      .pop_empty(pop_empty[i])
    );
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      done_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      done_q <= done_next;
      underflow_q <= underflow_q | (|pop_empty);
    end
  end
  assign bus.done = done_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_merger_coord_feeder.sv
// tb_merger_coord_feeder: directed vectors plus hand sequences for the coord feeder.
module tb_merger_coord_feeder;
  localparam logic [31:0] S = 32'hFFFF_FFFF;
  typedef struct {
    logic [1:0] vld, lst, fetch;
    logic [31:0] d0, d1;
    logic [1:0] rdy, lv;
    logic [31:0] c0, c1;
    logic dn, uf;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int passes = 0;
  vec_t tbl[9];
  always #5 clk = ~clk;
  merger_coord_feeder_if #(.W(32), .R(2)) bus ();
  merger_coord_feeder #(.MERGER_COORD_BITS(32), .MERGER_RADIX(2), .FIFO_DEPTH(4)) dut (
    .clock(clk),
    .reset_n(rst_n),
    .bus(bus)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic drive(input logic [1:0] vld, input logic [1:0] lst, input logic [1:0] fetch,
                       input logic [31:0] d0, input logic [31:0] d1);
    bus.in_valid = vld;
    bus.in_last = lst;
    bus.fetch_next = fetch;
    bus.in_coord = {d1, d0};
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk_all(input string tag, input logic [1:0] rdy, input logic [1:0] lv,
                         input logic [31:0] c0, input logic [31:0] c1, input logic dn, input logic uf);
    chk({tag, " in_ready"}, 64'(bus.in_ready), 64'(rdy));
    chk({tag, " lane_valid"}, 64'(bus.lane_valid), 64'(lv));
    chk({tag, " coord0"}, 64'(bus.coord_out[31:0]), 64'(c0));
    chk({tag, " coord1"}, 64'(bus.coord_out[63:32]), 64'(c1));
    chk({tag, " done"}, 64'(bus.done), 64'(dn));
    chk({tag, " underflow"}, 64'(bus.underflow), 64'(uf));
  endtask
  initial begin
    tbl[0] = '{2'b11, 2'b10, 2'b00, 32'd3, 32'd5, 2'b01, 2'b11, 32'd3, 32'd5, 1'b0, 1'b0};
    tbl[1] = '{2'b01, 2'b00, 2'b00, 32'd7, 32'd0, 2'b01, 2'b11, 32'd3, 32'd5, 1'b0, 1'b0};
    tbl[2] = '{2'b01, 2'b01, 2'b00, 32'd9, 32'd0, 2'b00, 2'b11, 32'd3, 32'd5, 1'b0, 1'b0};
    tbl[3] = '{2'b00, 2'b00, 2'b01, 32'd0, 32'd0, 2'b00, 2'b11, 32'd7, 32'd5, 1'b0, 1'b0};
    tbl[4] = '{2'b00, 2'b00, 2'b10, 32'd0, 32'd0, 2'b00, 2'b01, 32'd7, S, 1'b0, 1'b0};
    tbl[5] = '{2'b00, 2'b00, 2'b01, 32'd0, 32'd0, 2'b00, 2'b01, 32'd9, S, 1'b0, 1'b0};
    tbl[6] = '{2'b00, 2'b00, 2'b01, 32'd0, 32'd0, 2'b00, 2'b00, S, S, 1'b0, 1'b0};
    tbl[7] = '{2'b00, 2'b00, 2'b00, 32'd0, 32'd0, 2'b11, 2'b00, S, S, 1'b1, 1'b0};
    tbl[8] = '{2'b00, 2'b00, 2'b00, 32'd0, 32'd0, 2'b11, 2'b00, S, S, 1'b0, 1'b0};
    drive(2'b00, 2'b00, 2'b00, 32'd0, 32'd0);
    repeat (2) tick();
    chk_all("reset", 2'b00, 2'b00, S, S, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_all("release", 2'b11, 2'b00, S, S, 1'b0, 1'b0);
    for (int v = 0; v < 9; v++) begin
      drive(tbl[v].vld, tbl[v].lst, tbl[v].fetch, tbl[v].d0, tbl[v].d1);
      tick();
      chk_all($sformatf("merge v%0d", v), tbl[v].rdy, tbl[v].lv, tbl[v].c0, tbl[v].c1,
              tbl[v].dn, tbl[v].uf);
    end
    for (int k = 1; k <= 4; k++) begin
      drive(2'b01, 2'b00, 2'b00, 32'(k), 32'd0);
      tick();
    end
    chk("fill ready", 64'(bus.in_ready), 64'(2'b10));
    chk("fill head", 64'(bus.coord_out[31:0]), 64'd1);
    drive(2'b01, 2'b00, 2'b01, 32'd5, 32'd0);
    tick();
    chk("full pop ready", 64'(bus.in_ready), 64'(2'b11));
    chk("full pop head", 64'(bus.coord_out[31:0]), 64'd2);
    for (int k = 3; k <= 4; k++) begin
      drive(2'b00, 2'b00, 2'b01, 32'd0, 32'd0);
      tick();
      chk($sformatf("fill drain %0d", k), 64'(bus.coord_out[31:0]), 64'(k));
    end
    drive(2'b00, 2'b00, 2'b01, 32'd0, 32'd0);
    tick();
    chk("fill empty lv", 64'(bus.lane_valid), 64'(2'b00));
    chk("fill empty coord", 64'(bus.coord_out[31:0]), 64'(S));
    drive(2'b01, 2'b00, 2'b00, 32'd100, 32'd0);
    tick();
    chk("wrap first", 64'(bus.coord_out[31:0]), 64'd100);
    for (int k = 1; k < 20; k++) begin
      drive(2'b01, 2'b00, 2'b01, 32'(100 + k), 32'd0);
      tick();
      chk($sformatf("wrap head %0d", k), 64'(bus.coord_out[31:0]), 64'(100 + k));
      chk($sformatf("wrap lv %0d", k), 64'(bus.lane_valid), 64'(2'b01));
      chk($sformatf("wrap ready %0d", k), 64'(bus.in_ready), 64'(2'b11));
    end
    drive(2'b00, 2'b00, 2'b01, 32'd0, 32'd0);
    tick();
    chk("wrap drained", 64'(bus.lane_valid), 64'(2'b00));
    drive(2'b10, 2'b00, 2'b10, 32'd0, 32'd11);
    tick();
    chk_all("underflow", 2'b11, 2'b10, S, 32'd11, 1'b0, 1'b1);
    drive(2'b00, 2'b00, 2'b10, 32'd0, 32'd0);
    tick();
    chk_all("underflow pop", 2'b11, 2'b00, S, S, 1'b0, 1'b1);
    drive(2'b00, 2'b00, 2'b00, 32'd0, 32'd0);
    tick();
    chk("underflow sticky", 64'(bus.underflow), 64'd1);
    drive(2'b01, 2'b00, 2'b00, 32'd20, 32'd0);
    tick();
    drive(2'b01, 2'b01, 2'b00, 32'd21, 32'd0);
    tick();
    chk_all("midfiber", 2'b10, 2'b01, 32'd20, S, 1'b0, 1'b1);
    drive(2'b00, 2'b00, 2'b00, 32'd0, 32'd0);
    rst_n = 1'b0;
    tick();
    chk_all("midreset", 2'b00, 2'b00, S, S, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all($sformatf("post reset %0d", k), 2'b11, 2'b00, S, S, 1'b0, 1'b0);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
